envelope_detector: RTL and testbench

ENVELOPE_DETECTOR -- requirements
Module: envelope_detector

---
 rtl/envelope_detector.sv | 123 ++++++++++++
 tb/tb_envelope_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/envelope_detector.sv
// Two-stage audio envelope follower with separate attack and release time constants.
// Define ENVELOPE_DETECTOR_HOLD_EN to add a post-peak HOLD state of HOLD_SAMPLES valid samples.
module envelope_detector #(
  parameter int HOLD_SAMPLES = 16
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_valid,
  input  logic [7:0] i_data,
  input  logic [2:0] i_attack_shift,
  input  logic [3:0] i_release_shift,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic [7:0] o_env
);

  if (HOLD_SAMPLES < 1 || HOLD_SAMPLES > 255) begin : gBadHoldSamples
    $error("envelope_detector: HOLD_SAMPLES must be in 1..255");
  end

  logic [7:0]  absData;
  logic        valid1_q;
  logic [7:0]  data1_q;
  logic [7:0]  rect1_q;
  logic [2:0]  attackShift1_q;
  logic [3:0]  releaseShift1_q;
  logic [15:0] acc_q;

  logic [16:0] target;
  logic [16:0] attackDiff;
  logic [16:0] releaseDiff;
  logic [15:0] attackAcc_d;
  logic [15:0] releaseAcc_d;
  logic        isAttack;

  // -128 has no positive 8-bit counterpart, so it saturates to 127.
  always_comb begin
    absData = i_data;
    if (i_data[7]) begin
      absData = (i_data == 8'h80) ? 8'd127 : 8'(-i_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid1_q        <= 1'b0;
      data1_q         <= 8'd0;
      rect1_q         <= 8'd0;
      attackShift1_q  <= 3'd0;
      releaseShift1_q <= 4'd0;
    end else begin
      valid1_q <= i_valid;
      if (i_valid) begin
        data1_q         <= i_data;
        rect1_q         <= absData;
        attackShift1_q  <= i_attack_shift;
        releaseShift1_q <= i_release_shift;
      end
    end
  end

  // Both differences are non-negative on the branch that uses them, and the
  // result always lies between acc and the target, so nothing can wrap.
  always_comb begin
    target       = {1'b0, rect1_q, 8'h00};
    attackDiff   = target - {1'b0, acc_q};
    releaseDiff  = {1'b0, acc_q} - target;
    attackAcc_d  = acc_q + 16'(attackDiff >> attackShift1_q);
    releaseAcc_d = acc_q - 16'(releaseDiff >> releaseShift1_q);
    isAttack     = rect1_q > acc_q[15:8];
  end

`ifdef ENVELOPE_DETECTOR_HOLD_EN
  typedef enum logic [1:0] {ATTACK, HOLD, RELEASE} state_t;

  state_t     state_q;
  logic [7:0] holdCnt_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= RELEASE;
      holdCnt_q <= 8'd0;
      acc_q     <= 16'd0;
      o_valid   <= 1'b0;
      o_data    <= 8'd0;
    end else begin
      o_valid <= valid1_q;
      if (valid1_q) begin
        o_data <= data1_q;
        if (isAttack) begin
          acc_q     <= attackAcc_d;
          state_q   <= ATTACK;
          holdCnt_q <= 8'(HOLD_SAMPLES);
        end else if ((state_q == ATTACK || state_q == HOLD) && holdCnt_q != 8'd0) begin
          state_q   <= HOLD;
          holdCnt_q <= holdCnt_q - 8'd1;
        end else begin
          acc_q   <= releaseAcc_d;
          state_q <= RELEASE;
        end
      end
    end
  end
`else
  // Without hold, the decision depends only on the sample and acc, so no state register is kept.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q   <= 16'd0;
      o_valid <= 1'b0;
      o_data  <= 8'd0;
    end else begin
      o_valid <= valid1_q;
      if (valid1_q) begin
        o_data <= data1_q;
        acc_q  <= isAttack ? attackAcc_d : releaseAcc_d;
      end
    end
  end
`endif

  assign o_env = acc_q[15:8];

endmodule

// File: tb/tb_envelope_detector.sv
// Self-checking bench for envelope_detector: directed scenarios plus randomized traffic
// compared against an integer reference model (follows ENVELOPE_DETECTOR_HOLD_EN).
module tb_envelope_detector;

  localparam int HoldSamples = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       iValid = 1'b0;
  logic [7:0] iData = 8'd0;
  logic [2:0] iAttack = 3'd0;
  logic [3:0] iRelease = 4'd0;
  logic       oValid;
  logic [7:0] oData;
  logic [7:0] oEnv;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model state: envelope in 1/256 units plus hold bookkeeping.
  int modelAcc = 0;
  int modelHoldLeft = 0;
  bit modelPeak = 1'b0;
  bit pendValid = 1'b0;
  int pendData = 0;
  int pendEnv = 0;

  always #5 clk = ~clk;

  envelope_detector #(.HOLD_SAMPLES(HoldSamples)) dut (
    .i_clk          (clk),
    .i_reset_n      (resetN),
    .i_valid        (iValid),
    .i_data         (iData),
    .i_attack_shift (iAttack),
    .i_release_shift(iRelease),
    .o_valid        (oValid),
    .o_data         (oData),
    .o_env          (oEnv)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int rectify(input int s);
    if (s < 0) return (s == -128) ? 127 : -s;
    return s;
  endfunction

  task automatic modelSample(input int s, input int atk, input int rel);
    int r;
    int target;
    r = rectify(s);
    target = r * 256;
    if (r > modelAcc / 256) begin
      modelAcc = modelAcc + ((target - modelAcc) >> atk);
      modelPeak = 1'b1;
      modelHoldLeft = HoldSamples;
    end
`ifdef ENVELOPE_DETECTOR_HOLD_EN
    else if (modelPeak && modelHoldLeft > 0) begin
      modelHoldLeft--;
    end
`endif
    else begin
      modelAcc = modelAcc - ((modelAcc - target) >> rel);
      modelPeak = 1'b0;
    end
  endtask

  // Drives one cycle; afterwards the outputs show the sample driven on the previous call.
  task automatic applyStimulus(input bit v, input int d, input int atk, input int rel);
    iValid = v;
    iData = 8'(d);
    iAttack = 3'(atk);
    iRelease = 4'(rel);
    @(posedge clk);
    #1;
    checkOutput("o_valid", int'(oValid), int'(pendValid));
    checkOutput("o_env", int'(oEnv), pendEnv);
    if (pendValid) checkOutput("o_data", int'(oData), pendData);
    if (v) begin
      modelSample(d, atk, rel);
      pendData = d & 255;
    end
    pendValid = v;
    pendEnv = modelAcc / 256;
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    iValid = 1'b0;
    #1;
    checkOutput("rst_o_valid", int'(oValid), 0);
    checkOutput("rst_o_env", int'(oEnv), 0);
    checkOutput("rst_o_data", int'(oData), 0);
    modelAcc = 0;
    modelHoldLeft = 0;
    modelPeak = 1'b0;
    pendValid = 1'b0;
    pendEnv = 0;
    #1;
    resetN = 1'b1;
  endtask

  function automatic int expZero(input int j);
    int tail[3];
    tail = '{50, 25, 12};
`ifdef ENVELOPE_DETECTOR_HOLD_EN
    return (j < HoldSamples) ? 100 : tail[j - HoldSamples];
`else
    return tail[j];
`endif
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int zeroCount;
    int rampExp[4];
    int d;
    int sel;
    rampExp = '{32, 48, 56, 60};

    #12;
    resetDut();

    // Single sample, then the -128 saturation case.
    applyStimulus(1'b1, 100, 0, 0);
    applyStimulus(1'b0, 0, 0, 0);
    checkOutput("s100_valid", int'(oValid), 1);
    checkOutput("s100_env", int'(oEnv), 100);
    checkOutput("s100_data", int'(oData), 100);
    applyStimulus(1'b1, -128, 0, 0);
    applyStimulus(1'b0, 0, 0, 0);
    checkOutput("neg128_env", int'(oEnv), 127);
    checkOutput("neg128_data", int'(oData), 8'h80);

    // Decay from 100 with release shift 1, with or without hold.
`ifdef ENVELOPE_DETECTOR_HOLD_EN
    zeroCount = HoldSamples + 3;
`else
    zeroCount = 3;
`endif
    resetDut();
    applyStimulus(1'b1, 100, 0, 1);
    for (int k = 0; k <= zeroCount; k++) begin
      if (k < zeroCount) applyStimulus(1'b1, 0, 0, 1);
      else applyStimulus(1'b0, 0, 0, 1);
      checkOutput((k == 0) ? "decay_peak" : "decay_env", int'(oEnv), (k == 0) ? 100 : expZero(k - 1));
    end

    // Attack shift 1 ramp with idle gaps between samples.
    resetDut();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 64, 1, 0);
      applyStimulus(1'b0, 0, 1, 0);
      checkOutput("ramp_valid", int'(oValid), 1);
      checkOutput("ramp_env", int'(oEnv), rampExp[i]);
      applyStimulus(1'b0, 0, 1, 0);
      checkOutput("gap_valid", int'(oValid), 0);
      checkOutput("gap_env", int'(oEnv), rampExp[i]);
    end

    // Reset mid-stream with a sample still in flight.
    resetDut();
    applyStimulus(1'b1, 90, 0, 0);
    applyStimulus(1'b1, 50, 0, 0);
    checkOutput("pre_rst_env", int'(oEnv), 90);
    resetDut();
    applyStimulus(1'b1, 10, 0, 0);
    checkOutput("post_rst_valid", int'(oValid), 0);
    applyStimulus(1'b0, 0, 0, 0);
    checkOutput("post_rst_env", int'(oEnv), 10);
    checkOutput("post_rst_valid2", int'(oValid), 1);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) < 2) resetDut();
      sel = int'($urandom_range(0, 15));
      if (sel == 0) d = -128;
      else if (sel == 1) d = 127;
      else if (sel == 2) d = 0;
      else begin
        d = int'($urandom_range(0, 255));
        if (d > 127) d = d - 256;
      end
      applyStimulus($urandom_range(0, 3) != 0, d,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
    end
    applyStimulus(1'b0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
